// File: rtl/neopx_frame_streamer.sv
// Pixel frame buffer feeding the NeoPixel serializer over AXI-Stream.
// Host writes {W,R,G,B} words into RAM and pulses start; each pixel is read,
// brightness-scaled, reordered into wire order and emitted as one 32-bit beat.
module neopx_frame_streamer #(
  parameter int MAX_PIXELS = 64,
  parameter int ADDR_W     = 6,
  parameter int LED_TYPE   = 0
) (
  input  logic              axis_aclk,
  input  logic              axis_reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W:0]   num_pixels,
  input  logic [7:0]        brightness,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PRESENT
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_PIXELS);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [7:0]      bright_q, bright_d;
  logic [31:0]     tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            done_q, done_d;

  logic [31:0]     mem [MAX_PIXELS];
  logic [31:0]     rd_data_q;
  logic [31:0]     pix_word;
  logic [ADDR_W:0] num_clamped;

  // out = (c * (b + 1)) >> 8, so b = 255 passes through and b = 0 blanks
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * (16'(b) + 16'd1);
    return p[15:8];
  endfunction

  // Pixel RAM: sync write, sync read (old data on same-address collision), never reset
  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[idx_q[ADDR_W-1:0]];
  end

  // Scale each channel and reorder {W,R,G,B} into wire order {G,R,B,W|0}
  always_comb begin
    pix_word = {scale(rd_data_q[15:8],  bright_q),
                scale(rd_data_q[23:16], bright_q),
                scale(rd_data_q[7:0],   bright_q),
                (LED_TYPE == 1) ? scale(rd_data_q[31:24], bright_q) : 8'h00};
  end

  // Clamp requested frame length to the RAM depth
  always_comb begin
    num_clamped = num_pixels;
    if (num_pixels > MAX_CNT) num_clamped = MAX_CNT;
  end

  // Next-state and output-register logic for IDLE -> FETCH -> LOAD -> PRESENT
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    bright_d = bright_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            count_d  = num_clamped;
            bright_d = brightness;
            idx_d    = '0;
            state_d  = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tdata_d  = pix_word;
        tvalid_d = 1'b1;
        tlast_d  = (idx_q == count_q - ONE);
        state_d  = S_PRESENT;
      end
      S_PRESENT: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            tlast_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      count_q  <= '0;
      bright_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      bright_q <= bright_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign frame_done    = done_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_neopx_frame_streamer.sv
// Directed bench for neopx_frame_streamer: single-pixel vector table across
// both LED formats, then hand-written multi-cycle sequences.
module tb_neopx_frame_streamer;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        axis_reset;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  num_pixels;
  logic [7:0]  brightness;
  logic        start, start1;
  logic        tready;

  logic        busy, frame_done, tvalid, tlast;
  logic [31:0] tdata;
  logic        busy1, frame_done1, tvalid1, tlast1;
  logic [31:0] tdata1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  neopx_frame_streamer #(.MAX_PIXELS(64), .ADDR_W(6), .LED_TYPE(0)) dut (
    .axis_aclk(clk), .axis_reset(axis_reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .num_pixels(num_pixels), .brightness(brightness),
    .start(start), .busy(busy), .frame_done(frame_done), .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready)
  );

  neopx_frame_streamer #(.MAX_PIXELS(64), .ADDR_W(6), .LED_TYPE(1)) dut_w (
    .axis_aclk(clk), .axis_reset(axis_reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .num_pixels(num_pixels), .brightness(brightness),
    .start(start1), .busy(busy1), .frame_done(frame_done1), .m_axis_tdata(tdata1),
    .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1), .m_axis_tready(tready)
  );

  typedef struct {
    logic [31:0] word;
    logic [7:0]  bright;
    logic [31:0] exp_grb;
    logic [31:0] exp_grbw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_px(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [6:0] n, input logic [7:0] b, input logic both);
    num_pixels = n; brightness = b; start = 1'b1; start1 = both;
    tick();
    start = 1'b0; start1 = 1'b0;
  endtask

  // Called one negedge after start was sampled (or after a handshake)
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!tvalid && lat < LIMIT) begin
      tick();
      lat++;
    end
  endtask

  task automatic next_beat(output int lat);
    tick();
    wait_valid(lat);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, beats, last_at;
    logic [31:0] hold_d;
    logic hold_l, stable, quiet;

    vecs[0] = '{32'h00FFFFFF, 8'd127, 32'h7F7F7F00, 32'h7F7F7F00};
    vecs[1] = '{32'h00FFFFFF, 8'd0,   32'h00000000, 32'h00000000};
    vecs[2] = '{32'h11223344, 8'd255, 32'h33224400, 32'h33224411};
    vecs[3] = '{32'h80402010, 8'd255, 32'h20401000, 32'h20401080};
    vecs[4] = '{32'hFF808080, 8'd128, 32'h40404000, 32'h40404080};
    vecs[5] = '{32'h01020304, 8'd63,  32'h00000100, 32'h00000100};

    axis_reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    num_pixels = '0; brightness = '0; start = 1'b0; start1 = 1'b0; tready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    axis_reset = 1'b0;
    tick();

    // Single-pixel table on both formats
    for (int i = 0; i < 6; i++) begin
      write_px(6'd0, vecs[i].word);
      pulse_start(7'd1, vecs[i].bright, 1'b1);
      wait_valid(lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_grb", i), tdata, vecs[i].exp_grb);
      chk($sformatf("vec%0d_grbw", i), tdata1, vecs[i].exp_grbw);
      chk($sformatf("vec%0d_tlast", i), 32'(tlast), 32'd1);
      tick();
      chk($sformatf("vec%0d_done", i), 32'(frame_done), 32'd1);
    end

    // Three-pixel WS2812 frame, tready tied high
    write_px(6'd0, 32'h00FF0000);
    write_px(6'd1, 32'h0000FF00);
    write_px(6'd2, 32'h000000FF);
    pulse_start(7'd3, 8'd255, 1'b0);
    wait_valid(lat);
    chk("f3_lat0", 32'(lat), 32'd3);
    chk("f3_d0", tdata, 32'h00FF0000);
    chk("f3_l0", 32'(tlast), 32'd0);
    next_beat(lat);
    chk("f3_lat1", 32'(lat), 32'd3);
    chk("f3_d1", tdata, 32'hFF000000);
    chk("f3_l1", 32'(tlast), 32'd0);
    next_beat(lat);
    chk("f3_d2", tdata, 32'h0000FF00);
    chk("f3_l2", 32'(tlast), 32'd1);
    chk("f3_busy_during", 32'(busy), 32'd1);
    tick();
    chk("f3_done", 32'(frame_done), 32'd1);
    chk("f3_busy_fall", 32'(busy), 32'd0);
    chk("f3_tvalid_low", 32'(tvalid), 32'd0);
    tick();
    chk("f3_done_pulse", 32'(frame_done), 32'd0);

    // Backpressure: stall 20 cycles, ignored start, late write to unread index
    tready = 1'b0;
    pulse_start(7'd2, 8'd255, 1'b0);
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd3);
    chk("bp_d0", tdata, 32'h00FF0000);
    hold_d = tdata; hold_l = tlast; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tvalid !== 1'b1 || tdata !== hold_d || tlast !== hold_l) stable = 1'b0;
      if (i == 5) begin start = 1'b1; num_pixels = 7'd1; brightness = 8'd0; end
      if (i == 6) start = 1'b0;
      if (i == 8) begin wr_en = 1'b1; wr_addr = 6'd1; wr_data = 32'h000000AA; end
      if (i == 9) wr_en = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    tready = 1'b1;
    next_beat(lat);
    chk("bp_lat1", 32'(lat), 32'd3);
    chk("bp_d1", tdata, 32'h0000AA00);
    chk("bp_l1", 32'(tlast), 32'd1);
    tick();
    chk("bp_done", 32'(frame_done), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tvalid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) quiet = 1'b0;
    end
    chk("bp_no_ghost_frame", 32'(quiet), 32'd1);

    // Empty frame
    pulse_start(7'd0, 8'd255, 1'b0);
    chk("z_done", 32'(frame_done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tvalid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) quiet = 1'b0;
    end
    chk("z_quiet", 32'(quiet), 32'd1);

    // Oversized frame clamps to 64 beats
    for (int i = 0; i < 64; i++) write_px(6'(i), 32'(i));
    pulse_start(7'd100, 8'd255, 1'b0);
    beats = 0; last_at = 0;
    for (int k = 0; k < 70; k++) begin
      if (k == 0) wait_valid(lat);
      else next_beat(lat);
      if (!tvalid) break;
      beats = k + 1;
      chk($sformatf("clamp_d%0d", k), tdata, 32'(k) << 8);
      if (tlast) begin
        last_at = k + 1;
        break;
      end
    end
    chk("clamp_beats", 32'(beats), 32'd64);
    chk("clamp_last_at", 32'(last_at), 32'd64);
    tick();
    chk("clamp_done", 32'(frame_done), 32'd1);

    // Reset while presenting, then a fresh two-pixel frame
    tready = 1'b0;
    pulse_start(7'd3, 8'd255, 1'b0);
    wait_valid(lat);
    chk("mr_valid", 32'(tvalid), 32'd1);
    axis_reset = 1'b1;
    tick();
    chk("mr_tvalid", 32'(tvalid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    axis_reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (frame_done !== 1'b0 || tvalid !== 1'b0) quiet = 1'b0;
      tick();
    end
    chk("mr_no_done", 32'(quiet), 32'd1);
    tready = 1'b1;
    pulse_start(7'd2, 8'd255, 1'b0);
    wait_valid(lat);
    chk("mr_lat", 32'(lat), 32'd3);
    chk("mr_d0", tdata, 32'h00000000);
    chk("mr_l0", 32'(tlast), 32'd0);
    next_beat(lat);
    chk("mr_d1", tdata, 32'h00000100);
    chk("mr_l1", 32'(tlast), 32'd1);
    tick();
    chk("mr_done", 32'(frame_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
